md_hilo_unit: RTL and testbench
===============================

# md_hilo_unit

Parametrised multiply/divide unit with architectural HI/LO registers and an integrated E-stage result selector. It sits in the execute stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands, holds `busy` for a configurable per-operation latency, then commits HI/LO. It also drives the E-stage result word, chosen from the ALU output, HI or LO. Hazard logic in decode stalls on `start | busy` for any instruction that touches HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI, LO and result width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; must be ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: command strobe, sampled on the rising edge.
- `md_op`, in, 3: command. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- `a`, in, WIDTH: operand A (rs), or the move value for MTHI/MTLO.
- `b`, in, WIDTH: operand B (rt).
- `alu_out`, in, WIDTH: E-stage ALU result.
- `res_sel`, in, 2: result select. 0 `alu_out`, 1 HI, 2 LO, 3 all-zero.
- `busy`, out, 1: registered; high while an operation is in flight.
- `hi`, out, WIDTH: architectural HI register.
- `lo`, out, WIDTH: architectural LO register.
- `result`, out, WIDTH: combinational select per `res_sel`, using current `hi`/`lo`.

## Operation
- **Reset.** `hi`=0, `lo`=0 and `busy`=0; the counter and operand latches are cleared. An in-flight operation is discarded with no commit.
- **Accept.** On an edge with `start`=1 and `busy`=0:
  - MULT/MULTU/DIV/DIVU: latch `a`, `b` and `md_op`, load the counter with the op latency, and set `busy`=1.
  - MTHI/MTLO: write `a` to `hi`/`lo` at that edge; `busy` stays 0.
  - Ops 6–7: no effect.
- **Busy.** While `busy`=1, `start` is ignored for every op, including MTHI/MTLO. Pipeline stalls guarantee this never happens; the bench checks HI/LO stay unchanged if it does.
- **States.** IDLE(busy=0) → RUN(busy=1, counter>0). The counter decrements each edge. The edge at which the counter goes 1→0 commits HI/LO and returns to IDLE.
- **Arithmetic.** Results are computed from latched operands, so changes on `a`/`b` during RUN have no effect.
  - MULT: signed 2·WIDTH product; `hi`=upper WIDTH bits, `lo`=lower.
  - MULTU: unsigned 2·WIDTH product; same split.
  - DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend. Overflow case most-negative / −1 gives `lo`=most-negative, `hi`=0.
  - DIVU: unsigned; `lo`=quotient, `hi`=remainder.
  - Divide by zero (DIV or DIVU): `hi`=`a`, `lo`=all ones. Full latency still applies.
- **Result select.** `res_sel`=3 yields 0. `result` during RUN reflects the old HI/LO values.

## Timing
- Start of a mul/div sampled at edge T: `busy`=1 from after T through edge T+L, where L = MULT_CYCLES or DIV_CYCLES.
- At edge T+L, `busy` falls and the new HI/LO become visible simultaneously.
- Back-to-back: a new `start` is accepted at edge T+L+1 at the earliest. `start` exactly at edge T+L is ignored, because `busy` is still 1 there.
- MTHI/MTLO: new value visible after the sampling edge, so latency is 1.
- `result` has 0 cycles of latency with respect to `alu_out`, `res_sel`, `hi` and `lo`.
- Reset asserted mid-RUN: outputs clear immediately, independent of the clock. After deassertion the unit is IDLE, and the first edge may accept a `start`.

## Test plan
- **Reset.** Assert `reset` mid-RUN (MULT started, 2 cycles in) → `busy`=0 and `hi`=`lo`=0 at once; no commit occurs on later edges.
- **MULT timing.** MULT, a=0xFFFFFFFD, b=5 → `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **MULTU timing.** MULTU, same operands → `hi`=0x00000004, `lo`=0xFFFFFFF1 after 5 cycles.
- **DIV signs.** DIV a=0xFFFFFFF9 (−7), b=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Divide by zero and overflow.**
  - DIVU a=7, b=0 → `hi`=7, `lo`=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Moves, ignored commands and result select.**
  - MTHI a=0x12345678 → `hi` updates in 1 cycle with `busy`=0.
  - MTLO issued during RUN → ignored.
  - Sweep `res_sel` 0–3 with `alu_out`=0xA5A5A5A5 → outputs `alu_out`, `hi`, `lo`, then 0.

Source files
------------

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: multi-cycle multiply/divide unit with architectural HI/LO
// registers and the E-stage result selector (ALU / HI / LO / zero).
module md_hilo_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [1:0]       res_sel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic             busy_d;

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic                      div_zero;
   logic                      div_ovf;
   logic signed [WIDTH-1:0]   sdiv_den;
   logic signed [WIDTH-1:0]   sq, sr;
   logic        [WIDTH-1:0]   udiv_den;
   logic        [WIDTH-1:0]   uq, ur;
   logic        [WIDTH-1:0]   commit_hi, commit_lo;

   // Products from the latched operands, sign- or zero-extended to 2*WIDTH.
   assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Divide by zero and MIN/-1 are steered to a divisor of one: the zero case is
   // overridden below, and MIN/1 yields exactly the required MIN quotient, 0 remainder.
   assign div_zero = (b_q == '0);
   assign div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
   assign sdiv_den = (div_zero || div_ovf) ? WIDTH'(1) : $signed(b_q);
   assign udiv_den = div_zero ? WIDTH'(1) : b_q;
   assign sq       = $signed(a_q) / sdiv_den;
   assign sr       = $signed(a_q) % sdiv_den;
   assign uq       = a_q / udiv_den;
   assign ur       = a_q % udiv_den;

   // Values written to HI/LO when the in-flight operation completes.
   always_comb begin
      commit_hi = '0;
      commit_lo = '0;
      case (op_q)
         2'd0: begin
            commit_hi = prod_s[2*WIDTH-1:WIDTH];
            commit_lo = prod_s[WIDTH-1:0];
         end
         2'd1: begin
            commit_hi = prod_u[2*WIDTH-1:WIDTH];
            commit_lo = prod_u[WIDTH-1:0];
         end
         2'd2: begin
            commit_hi = div_zero ? a_q : sr;
            commit_lo = div_zero ? '1  : sq;
         end
         default: begin
            commit_hi = div_zero ? a_q : ur;
            commit_lo = div_zero ? '1  : uq;
         end
      endcase
   end

   // Next-state, operand latch and HI/LO update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi;
      lo_d    = lo;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = md_op[1:0];
                     a_d     = a;
                     b_d     = b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = md_op[1:0];
                     a_d     = a;
                     b_d     = b;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               hi_d    = commit_hi;
               lo_d    = commit_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
   end

   // State, counter, operand latches and architectural registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi      <= hi_d;
         lo      <= lo_d;
         busy    <= busy_d;
      end
   end

   // E-stage result select from current HI/LO; zero-latency path.
   always_comb begin
      result = '0;
      case (res_sel)
         2'd0:    result = alu_out;
         2'd1:    result = hi;
         2'd2:    result = lo;
         default: result = '0;
      endcase
   end

endmodule

// File: tb/tb_md_hilo_unit.sv
// tb_md_hilo_unit: table vectors, hand-written corner sequences and random
// operations checked against a 64-bit arithmetic reference model.
module tb_md_hilo_unit;

   localparam int unsigned W  = 32;
   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [2:0]    md_op;
   logic [W-1:0]  a, b, alu_out;
   logic [1:0]    res_sel;
   logic          busy;
   logic [W-1:0]  hi, lo, result;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t tbl [12];

   md_hilo_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .a       (a),
      .b       (b),
      .alu_out (alu_out),
      .res_sel (res_sel),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [W-1:0] sel_ref(input logic [1:0] s, input logic [W-1:0] alu,
                                            input logic [W-1:0] h, input logic [W-1:0] l);
      case (s)
         2'd0:    return alu;
         2'd1:    return h;
         2'd2:    return l;
         default: return '0;
      endcase
   endfunction

   // Reference: plain 64-bit arithmetic on the architectural definition of each op.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] ch, input logic [W-1:0] cl,
                                 output logic [W-1:0] nh, output logic [W-1:0] nl);
      longint sa, sb, q, r;
      logic [63:0] p;
      nh = ch;
      nl = cl;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (op)
         3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
         3'd1: begin p = 64'(av) * 64'(bv); nh = p[63:32]; nl = p[31:0]; end
         3'd2: begin
            if (bv == 0) begin nh = av; nl = '1; end
            else begin q = sa / sb; r = sa - q * sb; nh = r[31:0]; nl = q[31:0]; end
         end
         3'd3: begin
            if (bv == 0) begin nh = av; nl = '1; end
            else begin nh = av % bv; nl = av / bv; end
         end
         3'd4: nh = av;
         3'd5: nl = av;
         default: ;
      endcase
   endfunction

   // Issue one command, watch the busy window, then check the committed HI/LO.
   // junk=1 issues an MTLO mid-run; junk=2 issues an MTHI on the completing edge.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input int junk);
      int lat;
      int n;
      lat = (op <= 3'd1) ? int'(MC) : (op <= 3'd3) ? int'(DC) : 0;
      start = 1'b1; md_op = op; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         n++;
         check("run_hi", hi, exp_hi);
         check("run_lo", lo, exp_lo);
         res_sel = 2'($urandom_range(0, 3));
         alu_out = $urandom;
         #1 check("run_result", result, sel_ref(res_sel, alu_out, exp_hi, exp_lo));
         start = 1'b0;
         if (junk == 1 && n == 2)   begin start = 1'b1; md_op = 3'd5; a = $urandom; end
         if (junk == 2 && n == lat) begin start = 1'b1; md_op = 3'd4; a = $urandom; end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_len", 32'(n), 32'(lat));
      check("hi", hi, ehi);
      check("lo", lo, elo);
      exp_hi = ehi;
      exp_lo = elo;
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] av, bv, nh, nl;
      int           k;

      reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
      alu_out = '0; res_sel = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, '0);
      check("reset_lo", lo, '0);
      reset = 1'b0;
      @(negedge clk);

      tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[1]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
      tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3]  = '{3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
      tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[5]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000};
      tbl[6]  = '{3'd5, 32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D};
      tbl[7]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
      tbl[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[9]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      tbl[10] = '{3'd6, 32'd1,        32'd1,        32'hFFFFFFF9, 32'hFFFFFFFF};
      tbl[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      for (int i = 0; i < 12; i++)
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, i % 3);

      // Result select sweep against fixed ALU value.
      alu_out = 32'hA5A5A5A5;
      for (int s = 0; s < 4; s++) begin
         res_sel = 2'(s);
         #1 check("res_sel_sweep", result, (s == 0) ? 32'hA5A5A5A5 : (s == 1) ? 32'h00000001 :
                                           (s == 2) ? 32'hFFFFFFFD : 32'h00000000);
      end
      @(negedge clk);

      // Reset two cycles into a MULT: immediate clear, no commit afterwards.
      start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_hi", hi, '0);
      check("async_rst_lo", lo, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (MC + 3) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_hi", hi, '0);
      check("post_rst_lo", lo, '0);
      exp_hi = '0;
      exp_lo = '0;

      // First edge after reset release accepts a command.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      do_op(3'd1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 2);

      // Random commands against the reference model.
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         av = $urandom;
         bv = $urandom;
         k  = int'($urandom_range(0, 7));
         if (k == 0) bv = '0;
         if (k == 1) begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
         if (k == 2) bv = 32'($urandom_range(1, 9));
         model(op, av, bv, exp_hi, exp_lo, nh, nl);
         do_op(op, av, bv, nh, nl, int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
